// File: rtl/multitap_delay_mem.sv
// multitap_delay_mem: circular-buffer sample RAM with NUM_TAPS programmable delayed reads per sample
module multitap_delay_mem #(
  parameter int DATA_WIDTH = 31,
  parameter int ADDR_WIDTH = 15,
  parameter int SIZE       = 20000,
  parameter int NUM_TAPS   = 4
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           IN_VALID,
  input  logic [DATA_WIDTH-1:0]          DI,
  input  logic [NUM_TAPS*ADDR_WIDTH-1:0] DELAY,
  input  logic                           CLEAR,
  output logic                           BUSY,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] DO,
  output logic                           OUT_VALID,
  output logic                           OVERRUN
);
  localparam int KW = NUM_TAPS > 1 ? $clog2(NUM_TAPS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] SZ   = ADDR_WIDTH'(SIZE);
  localparam logic [KW-1:0]         KLAST = KW'(NUM_TAPS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_OUT, S_CLR} state_t;

  state_t                         r_state, w_next;
  logic [ADDR_WIDTH-1:0]          r_wr_ptr, r_fill, r_clr_addr;
  logic [KW-1:0]                  r_k, r_cap_k;
  logic [DATA_WIDTH-1:0]          r_di, r_rd_data;
  logic [NUM_TAPS*ADDR_WIDTH-1:0] r_delay;
  logic [NUM_TAPS*DATA_WIDTH-1:0] r_shadow;
  logic                           r_cap_pend, r_cap_zero, r_cap_byp;
  logic [DATA_WIDTH-1:0]          r_mem [SIZE];

  logic [ADDR_WIDTH-1:0] w_d, w_dc, w_rd_addr, w_wa;
  logic [DATA_WIDTH-1:0] w_wd, w_tap;
  logic                  w_we, w_accept;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = CLEAR ? S_CLR : IN_VALID ? S_RD : S_IDLE;
      S_RD:    w_next = r_k == KLAST ? S_WR : S_RD;
      S_WR:    w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      S_CLR:   w_next = r_clr_addr == LAST ? S_IDLE : S_CLR;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY     = r_state != S_IDLE;
    w_accept = r_state == S_IDLE && IN_VALID && !CLEAR;
    w_we     = r_state == S_WR || r_state == S_CLR;
    w_wa     = r_state == S_CLR ? r_clr_addr : r_wr_ptr;
    w_wd     = r_state == S_CLR ? '0 : r_di;
  end

  // Clamped delay and wrap-around read address without a modulo
  always_comb begin
    w_d       = r_delay[r_k*ADDR_WIDTH +: ADDR_WIDTH];
    w_dc      = w_d > LAST ? LAST : w_d;
    w_rd_addr = r_wr_ptr >= w_dc ? r_wr_ptr - w_dc : r_wr_ptr + SZ - w_dc;
    w_tap     = r_cap_byp ? r_di : r_cap_zero ? '0 : r_rd_data;
  end

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_wa] <= w_wd;
    if (r_state == S_RD) r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_clr_addr <= '0;
      r_k        <= '0;
      r_cap_k    <= '0;
      r_cap_pend <= 1'b0;
      r_cap_zero <= 1'b0;
      r_cap_byp  <= 1'b0;
      r_di       <= '0;
      r_delay    <= '0;
      r_shadow   <= '0;
      DO         <= '0;
      OUT_VALID  <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      if (IN_VALID && BUSY) OVERRUN <= 1'b1;
      OUT_VALID  <= r_state == S_OUT;
      if (r_state == S_OUT) DO <= r_shadow;
      // Tap substitution flags travel with the read to match the RAM latency
      r_cap_pend <= r_state == S_RD;
      r_cap_k    <= r_k;
      r_cap_zero <= w_dc > r_fill;
      r_cap_byp  <= w_dc == '0;
      if (r_cap_pend) r_shadow[r_cap_k*DATA_WIDTH +: DATA_WIDTH] <= w_tap;
      if (r_state == S_IDLE && CLEAR) r_clr_addr <= '0;
      if (w_accept) begin
        r_di    <= DI;
        r_delay <= DELAY;
        r_k     <= '0;
      end
      if (r_state == S_RD) r_k <= r_k + KW'(1);
      if (r_state == S_WR) begin
        r_wr_ptr <= r_wr_ptr == LAST ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
        r_fill   <= r_fill == LAST ? LAST : r_fill + ADDR_WIDTH'(1);
      end
      if (r_state == S_CLR) begin
        r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
        if (r_clr_addr == LAST) begin
          r_wr_ptr <= '0;
          r_fill   <= LAST;
        end
      end
    end
endmodule

// File: tb/tb_multitap_delay_mem.sv
// tb_multitap_delay_mem: directed vectors with hand-computed taps for SIZE=8, NUM_TAPS=2, DATA_WIDTH=8
module tb_multitap_delay_mem;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [7:0]  DI = '0;
  logic [7:0]  DELAY = '0;
  logic        CLEAR = 1'b0;
  logic        BUSY;
  logic [15:0] DO;
  logic        OUT_VALID;
  logic        OVERRUN;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] dout;

  multitap_delay_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .SIZE(8), .NUM_TAPS(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .DI(DI), .DELAY(DELAY), .CLEAR(CLEAR),
    .BUSY(BUSY), .DO(DO), .OUT_VALID(OUT_VALID), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; ovr holds IN_VALID over one busy edge
  task automatic send(input logic [7:0] di, input logic [7:0] dly, input logic ovr, output logic [15:0] q);
    int n;
    IN_VALID = 1'b1;
    DI = di;
    DELAY = dly;
    @(posedge CLK);
    #1;
    if (ovr) DI = 8'h99;
    else IN_VALID = 1'b0;
    n = 0;
    while (!OUT_VALID && n < 20) begin
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      n++;
    end
    chk("latency", n, 4);
    q = DO;
  endtask

  initial begin
    int n;
    logic ov;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_ov", OUT_VALID, 0);
    chk("rst_do", DO, 0);
    chk("rst_ovr", OVERRUN, 0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    send(8'h11, {4'd1, 4'd0}, 1'b0, dout);
    chk("first", dout, 16'h0011);
    for (int i = 1; i <= 10; i++) begin
      send(8'(i), {4'd3, 4'd1}, 1'b0, dout);
      if (i == 1) chk("fill1", dout, 16'h0011);
    end
    chk("wrap10", dout, 16'h0709);
    send(8'h20, {4'd15, 4'd7}, 1'b0, dout);
    chk("clamp", dout, 16'h0404);
    send(8'h30, {4'd1, 4'd1}, 1'b1, dout);
    chk("ovr_taps", dout, 16'h2020);
    chk("ovr_set", OVERRUN, 1);
    send(8'h31, {4'd2, 4'd1}, 1'b0, dout);
    chk("ovr_drop", dout, 16'h2030);
    chk("ovr_sticky", OVERRUN, 1);
    CLEAR = 1'b1;
    IN_VALID = 1'b1;
    DI = 8'h77;
    @(posedge CLK);
    #1;
    CLEAR = 1'b0;
    IN_VALID = 1'b0;
    n = 0;
    ov = 1'b0;
    while (BUSY && n < 50) begin
      if (OUT_VALID) ov = 1'b1;
      n++;
      @(posedge CLK);
      #1;
    end
    chk("clr_busy", n, 8);
    chk("clr_noval", ov, 0);
    chk("clr_do", DO, 16'h2030);
    send(8'h40, {4'd5, 4'd2}, 1'b0, dout);
    chk("clr_taps", dout, 16'h0000);
    IN_VALID = 1'b1;
    DI = 8'h50;
    DELAY = 8'h00;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("ar_busy", BUSY, 0);
    chk("ar_ov", OUT_VALID, 0);
    chk("ar_do", DO, 0);
    chk("ar_ovr", OVERRUN, 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    send(8'h55, {4'd0, 4'd1}, 1'b0, dout);
    chk("ar_taps", dout, 16'h5500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
